// File: rtl/bit_serial_alu_pkg.sv
// Shared op codes and FSM state encoding for the bit-serial ALU.
package bit_serial_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // SUB and SLT both compute A + ~B + 1, so B is inverted and carry-in starts at 1.
  function automatic logic op_inverts_b(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/bit_serial_alu_bit_slice.sv
// Combinational 1-bit ALU slice; the serial datapath pushes one bit per cycle through it.
module alu_bit_slice
  import bit_serial_alu_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  output logic       y,
  output logic       cout
);

  logic w_b;
  logic w_sum;
  logic w_cy;

  always_comb begin
    w_b   = op_inverts_b(op) ? ~b : b;
    w_sum = a ^ w_b ^ cin;
    w_cy  = (a & w_b) | (a & cin) | (w_b & cin);
  end

  always_comb begin
    y    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOR: y = ~(a | b);
      OP_ADD, OP_SUB, OP_SLT: begin
        y    = w_sum;
        cout = w_cy;
      end
      default: begin
        y    = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: accepts one operation, processes it LSB first over WIDTH cycles,
// then holds result and flags until the consumer acknowledges.
module bit_serial_alu
  import bit_serial_alu_pkg::*;
#(
  parameter int WIDTH = 32
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_cin;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_overflow;
  logic             r_zero;

  logic             w_y;
  logic             w_cout;
  logic             w_last;
  logic             w_ovf;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_final;

  alu_bit_slice u_slice (
    .op   (r_op),
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_cin),
    .y    (w_y),
    .cout (w_cout)
  );

  assign w_last    = (r_cnt == LAST_BIT);
  assign w_ovf     = r_cin ^ w_cout;
  assign w_shifted = {w_y, r_result[WIDTH-1:1]};

  // On the MSB cycle SLT collapses to a single bit: sign of A-B corrected by overflow.
  always_comb begin
    w_final = w_shifted;
    if (r_op == OP_SLT) begin
      w_final    = '0;
      w_final[0] = w_y ^ w_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= OP_AND;
      r_cin      <= 1'b0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cin   <= op_inverts_b(op);
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_cin <= w_cout;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result   <= w_final;
            r_carry    <= op_is_arith(r_op) & w_cout;
            r_overflow <= op_is_arith(r_op) & w_ovf;
            r_zero     <= (w_final == '0);
            r_state    <= ST_DONE;
          end else begin
            r_result <= w_shifted;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule
